// File: rtl/simple_iface.sv
// rtl/simple_iface.sv - 8-bit data holding register with write bookkeeping
module simple_iface #(
    parameter int               DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter logic [7:0]        INST_ID   = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              changed,
    output logic [7:0]        wr_count,
    output logic [7:0]        inst_id
);

    assign inst_id = INST_ID;

    // clr takes priority over wr_en: a write in a clearing cycle is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= RESET_VAL;
            valid    <= 1'b0;
            changed  <= 1'b0;
            wr_count <= 8'd0;
        end else if (clr) begin
            data     <= RESET_VAL;
            valid    <= 1'b0;
            changed  <= 1'b0;
            wr_count <= 8'd0;
        end else if (wr_en) begin
            data    <= wr_data;
            valid   <= 1'b1;
            changed <= (wr_data != data);
            if (wr_count != 8'hFF) begin
                wr_count <= wr_count + 8'd1;
            end
        end else begin
            changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_simple_iface.sv
// tb/tb_simple_iface.sv - randomized self-checking bench for simple_iface
module tb_simple_iface;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] wr_en = '0;
    logic [2:0] clr = '0;
    logic [7:0] wr_data [3];
    logic [7:0] d_data [3];
    logic       d_valid [3];
    logic       d_changed [3];
    logic [7:0] d_count [3];
    logic [7:0] d_id [3];

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_data [3];
    bit         m_valid [3];
    bit         m_changed [3];
    int         m_count [3];
    logic [7:0] rv [3];

    always #5 clk = ~clk;

    simple_iface #(.INST_ID(8'd1)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .clr(clr[0]),
        .data(d_data[0]), .valid(d_valid[0]), .changed(d_changed[0]),
        .wr_count(d_count[0]), .inst_id(d_id[0])
    );
    simple_iface #(.INST_ID(8'd2)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .clr(clr[1]),
        .data(d_data[1]), .valid(d_valid[1]), .changed(d_changed[1]),
        .wr_count(d_count[1]), .inst_id(d_id[1])
    );
    simple_iface #(.INST_ID(8'd3), .RESET_VAL(8'h3C)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .clr(clr[2]),
        .data(d_data[2]), .valid(d_valid[2]), .changed(d_changed[2]),
        .wr_count(d_count[2]), .inst_id(d_id[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_data[i]    = rv[i];
        m_valid[i]   = 1'b0;
        m_changed[i] = 1'b0;
        m_count[i]   = 0;
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("data%0d", i), {24'd0, d_data[i]}, {24'd0, m_data[i]});
            check($sformatf("valid%0d", i), {31'd0, d_valid[i]}, {31'd0, m_valid[i]});
            check($sformatf("changed%0d", i), {31'd0, d_changed[i]}, {31'd0, m_changed[i]});
            check($sformatf("count%0d", i), {24'd0, d_count[i]}, m_count[i]);
            check($sformatf("id%0d", i), {24'd0, d_id[i]}, i + 1);
        end
    endtask

    // advance one clock edge, apply the held inputs to the model, then compare
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rst_n || clr[i]) begin
                model_reset(i);
            end else if (wr_en[i]) begin
                m_changed[i] = (wr_data[i] != m_data[i]);
                m_data[i]    = wr_data[i];
                m_valid[i]   = 1'b1;
                m_count[i]   = (m_count[i] < 255) ? m_count[i] + 1 : 255;
            end else begin
                m_changed[i] = 1'b0;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle_all();
        wr_en = '0;
        clr   = '0;
    endtask

    task automatic wr(input int i, input logic [7:0] d);
        wr_en[i]   = 1'b1;
        wr_data[i] = d;
    endtask

    initial begin
        rv[0] = 8'h00;
        rv[1] = 8'h00;
        rv[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            wr_data[i] = 8'h00;
            model_reset(i);
        end

        // reset held with clock running, then idle
        wr_en = 3'b111;
        wr_data[0] = 8'hEE;
        repeat (3) step();
        rst_n = 1'b1;
        idle_all();
        repeat (3) step();

        // distinct value per instance
        wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33);
        step();
        idle_all();
        step();
        wr(0, 8'h44);
        step();
        wr(0, 8'h55);
        step();
        idle_all();
        step();

        // same-value write, then a changing one
        wr(1, 8'hA5);
        step();
        step();
        wr(1, 8'h5A);
        step();
        idle_all();
        step();

        // clear wins over a simultaneous write
        wr(0, 8'hFF); wr(1, 8'hFF); wr(2, 8'hFF);
        clr = 3'b111;
        step();
        idle_all();
        step();

        // first write equal to RESET_VAL after a clear
        wr(2, 8'h3C);
        step();
        idle_all();

        // saturation burst on instance 0, random traffic elsewhere
        for (int n = 0; n < 300; n++) begin
            wr(0, 8'($urandom));
            wr_en[1]   = 1'($urandom);
            wr_data[1] = 8'($urandom_range(0, 3));
            step();
        end
        idle_all();
        step();
        check("sat_count", {24'd0, d_count[0]}, 32'd255);

        // fully random traffic with occasional clears
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 3; i++) begin
                wr_en[i]   = 1'($urandom_range(0, 3) != 0);
                clr[i]     = ($urandom_range(0, 15) == 0);
                wr_data[i] = 8'($urandom_range(0, 7));
            end
            step();
        end

        // async reset between edges during a write burst
        for (int i = 0; i < 3; i++) wr(i, 8'($urandom) | 8'h80);
        clr = '0;
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) model_reset(i);
        check_all();
        step();
        rst_n = 1'b1;
        idle_all();
        wr(2, 8'h3C);
        step();
        idle_all();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
